// File: rtl/mbist_march_subsystem.sv
// MBIST subsystem: CPU/test memory mux plus a MATS+ / March C- engine with pipelined compare.
// Optional feature: define MBIST_STOP_ON_FAIL_EN to end a run on the first retired mismatch.
module mbist_march_subsystem #(
    parameter int ADDR   = 4,
    parameter int DATA   = 8,
    parameter int RD_LAT = 1,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              test_mode,
    input  logic              start,
    input  logic              alg_sel,
    input  logic [DATA-1:0]   bg_pattern,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR-1:0]   cpu_addr,
    input  logic [DATA-1:0]   cpu_din,
    output logic [DATA-1:0]   cpu_dout,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR-1:0]   mem_addr,
    output logic [DATA-1:0]   mem_din,
    input  logic [DATA-1:0]   mem_dout,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR-1:0]   fail_addr,
    output logic [DATA-1:0]   fail_data,
    output logic [FCNT_W-1:0] fail_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic is_down(input logic alg, input logic [2:0] e);
        return alg ? (e == 3'd3 || e == 3'd4) : (e == 3'd2);
    endfunction

    function automatic logic is_last(input logic alg, input logic [2:0] e);
        return alg ? (e == 3'd5) : (e == 3'd2);
    endfunction

    function automatic logic is_pair(input logic alg, input logic [2:0] e);
        return (e != 3'd0) && !(alg && e == 3'd5);
    endfunction

    state_t              state_q;
    logic                alg_q;
    logic [DATA-1:0]     bg_q;
    logic [2:0]          elem_q;
    logic                op_q;
    logic [ADDR-1:0]     addr_q;
    logic                eng_rd_q, eng_wr_q;
    logic [ADDR-1:0]     eng_addr_q;
    logic [DATA-1:0]     eng_din_q;
    logic [2:0]          drain_q;
    logic                busy_q, done_q, fail_q;
    logic [ADDR-1:0]     fail_addr_q;
    logic [DATA-1:0]     fail_data_q;
    logic [FCNT_W-1:0]   fail_cnt_q;

    logic [RD_LAT-1:0]   pv_q;
    logic [ADDR-1:0]     pa_q [RD_LAT];
    logic [DATA-1:0]     pe_q [RD_LAT];

    logic                cur_down, at_end, last_op;
    logic [2:0]          elem_d;
    logic                op_d;
    logic [ADDR-1:0]     addr_d;
    logic                launch, active, abort, miss, stop;
    logic [DATA-1:0]     p_bg;
    logic [2:0]          p_elem;
    logic                p_op, p_wr, p_v;
    logic [ADDR-1:0]     p_addr;
    logic [DATA-1:0]     p_data;

    assign launch = (state_q == IDLE || state_q == DONE) && test_mode && start;
    assign active = (state_q == RUN) || (state_q == DRAIN);
    assign abort  = active && !test_mode;
    assign miss   = active && test_mode && pv_q[RD_LAT-1]
                    && (mem_dout != pe_q[RD_LAT-1]);

`ifdef MBIST_STOP_ON_FAIL_EN
    assign stop = miss;
`else
    assign stop = 1'b0;
`endif

    always_comb begin
        cur_down = is_down(alg_q, elem_q);
        at_end   = cur_down ? (addr_q == '0) : (addr_q == '1);
        elem_d   = elem_q;
        op_d     = 1'b0;
        addr_d   = addr_q;
        last_op  = 1'b0;
        if (!op_q && is_pair(alg_q, elem_q)) begin
            op_d = 1'b1;
        end else if (!at_end) begin
            addr_d = cur_down ? addr_q - ADDR'(1) : addr_q + ADDR'(1);
        end else if (is_last(alg_q, elem_q)) begin
            last_op = 1'b1;
        end else begin
            elem_d = elem_q + 3'd1;
            addr_d = is_down(alg_q, elem_q + 3'd1) ? '1 : '0;
        end
    end

    // Elements after the first are (r x, w ~x) or a lone r x, with x = 1 on even elements.
    always_comb begin
        if (launch) begin
            p_bg   = bg_pattern;
            p_elem = 3'd0;
            p_op   = 1'b0;
            p_addr = '0;
        end else begin
            p_bg   = bg_q;
            p_elem = elem_d;
            p_op   = op_d;
            p_addr = addr_d;
        end
        p_wr   = (p_elem == 3'd0) || p_op;
        p_v    = (p_elem != 3'd0) && (p_op ? p_elem[0] : !p_elem[0]);
        p_data = p_v ? ~p_bg : p_bg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            alg_q       <= 1'b0;
            bg_q        <= '0;
            elem_q      <= '0;
            op_q        <= 1'b0;
            addr_q      <= '0;
            eng_rd_q    <= 1'b0;
            eng_wr_q    <= 1'b0;
            eng_addr_q  <= '0;
            eng_din_q   <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            if (miss) begin
                if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + FCNT_W'(1);
                if (!fail_q) begin
                    fail_q      <= 1'b1;
                    fail_addr_q <= pa_q[RD_LAT-1];
                    fail_data_q <= mem_dout ^ pe_q[RD_LAT-1];
                end
            end
            case (state_q)
                IDLE, DONE: begin
                    if (launch) begin
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        alg_q       <= alg_sel;
                        bg_q        <= bg_pattern;
                        fail_q      <= 1'b0;
                        fail_addr_q <= '0;
                        fail_data_q <= '0;
                        fail_cnt_q  <= '0;
                        elem_q      <= p_elem;
                        op_q        <= p_op;
                        addr_q      <= p_addr;
                        eng_rd_q    <= !p_wr;
                        eng_wr_q    <= p_wr;
                        eng_addr_q  <= p_addr;
                        eng_din_q   <= p_data;
                    end else if (!test_mode) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                RUN, DRAIN: begin
                    if (abort) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b0;
                        eng_rd_q <= 1'b0;
                        eng_wr_q <= 1'b0;
                    end else if (stop || (state_q == DRAIN && drain_q == 3'd0)) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        eng_rd_q <= 1'b0;
                        eng_wr_q <= 1'b0;
                    end else if (state_q == DRAIN) begin
                        drain_q <= drain_q - 3'd1;
                    end else if (last_op) begin
                        state_q  <= DRAIN;
                        drain_q  <= 3'(RD_LAT - 1);
                        eng_rd_q <= 1'b0;
                        eng_wr_q <= 1'b0;
                    end else begin
                        elem_q     <= p_elem;
                        op_q       <= p_op;
                        addr_q     <= p_addr;
                        eng_rd_q   <= !p_wr;
                        eng_wr_q   <= p_wr;
                        eng_addr_q <= p_addr;
                        eng_din_q  <= p_data;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q <= '0;
        end else if (abort || stop) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= eng_rd_q;
            for (int i = 1; i < RD_LAT; i++) pv_q[i] <= pv_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pa_q[0] <= eng_addr_q;
        pe_q[0] <= eng_din_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pa_q[i] <= pa_q[i-1];
            pe_q[i] <= pe_q[i-1];
        end
    end

    assign mem_rd    = test_mode ? eng_rd_q   : cpu_rd;
    assign mem_wr    = test_mode ? eng_wr_q   : cpu_wr;
    assign mem_addr  = test_mode ? eng_addr_q : cpu_addr;
    assign mem_din   = test_mode ? eng_din_q  : cpu_din;
    assign cpu_dout  = mem_dout;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_mbist_march_subsystem.sv
// Directed bench for mbist_march_subsystem: RD_LAT=1 and RD_LAT=3 instances
// side by side, each with a small behavioural SRAM and an injectable stuck-at-1 fault.
module tb_mbist_march_subsystem;

    logic       clk = 1'b0;
    logic       rst;
    logic       test_mode, start, alg_sel;
    logic [7:0] bg_pattern;
    logic       cpu_rd, cpu_wr;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_din;

    logic [7:0] cpu_dout1, mem_din1, mem_dout1, fail_data1, fail_cnt1;
    logic [3:0] mem_addr1, fail_addr1;
    logic       mem_rd1, mem_wr1, busy1, done1, fail1;
    logic [7:0] cpu_dout3, mem_din3, mem_dout3, fail_data3, fail_cnt3;
    logic [3:0] mem_addr3, fail_addr3;
    logic       mem_rd3, mem_wr3, busy3, done3, fail3;

    logic [7:0] ram1 [16];
    logic [7:0] ram3 [16];
    logic [7:0] s3 [3];
    logic       f1_en, f3_en;
    logic [3:0] f1_a, f3_a;

    int n_chk, n_fail;
    int d1_c, d3_c, ops1;
    logic       first_wr;
    logic [7:0] first_din;

    always #5 clk = ~clk;

    mbist_march_subsystem #(.ADDR(4), .DATA(8), .RD_LAT(1), .FCNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .test_mode(test_mode), .start(start),
        .alg_sel(alg_sel), .bg_pattern(bg_pattern),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout1), .mem_rd(mem_rd1), .mem_wr(mem_wr1),
        .mem_addr(mem_addr1), .mem_din(mem_din1), .mem_dout(mem_dout1),
        .busy(busy1), .done(done1), .fail(fail1), .fail_addr(fail_addr1),
        .fail_data(fail_data1), .fail_cnt(fail_cnt1)
    );

    mbist_march_subsystem #(.ADDR(4), .DATA(8), .RD_LAT(3), .FCNT_W(8)) u_dut3 (
        .clk(clk), .rst(rst), .test_mode(test_mode), .start(start),
        .alg_sel(alg_sel), .bg_pattern(bg_pattern),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout3), .mem_rd(mem_rd3), .mem_wr(mem_wr3),
        .mem_addr(mem_addr3), .mem_din(mem_din3), .mem_dout(mem_dout3),
        .busy(busy3), .done(done3), .fail(fail3), .fail_addr(fail_addr3),
        .fail_data(fail_data3), .fail_cnt(fail_cnt3)
    );

    always @(posedge clk) begin
        if (mem_wr1) ram1[mem_addr1] <= mem_din1;
        if (mem_rd1)
            mem_dout1 <= ram1[mem_addr1] | ((f1_en && mem_addr1 == f1_a) ? 8'h08 : 8'h00);
    end

    always @(posedge clk) begin
        if (mem_wr3) ram3[mem_addr3] <= mem_din3;
        if (mem_rd3)
            s3[0] <= ram3[mem_addr3] | ((f3_en && mem_addr3 == f3_a) ? 8'h08 : 8'h00);
        s3[1] <= s3[0];
        s3[2] <= s3[1];
    end
    assign mem_dout3 = s3[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_march(input logic alg, input logic [7:0] bg, input int stop_c);
        @(negedge clk);
        test_mode  = 1'b1;
        alg_sel    = alg;
        bg_pattern = bg;
        start      = 1'b1;
        d1_c = 0;
        d3_c = 0;
        ops1 = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) begin
                first_wr  = mem_wr1;
                first_din = mem_din1;
                start     = 1'b0;
            end
            if (mem_rd1 || mem_wr1) ops1++;
            if (done1 && d1_c == 0) d1_c = c;
            if (done3 && d3_c == 0) d3_c = c;
            if (c == stop_c) break;
            if (d1_c != 0 && d3_c != 0) break;
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        test_mode = 1'b0;
        start = 1'b0;
        alg_sel = 1'b0;
        bg_pattern = 8'h00;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        cpu_addr = 4'h0;
        cpu_din = 8'h00;
        f1_en = 1'b0;
        f3_en = 1'b0;
        f1_a = 4'h0;
        f3_a = 4'h0;
        #12;
        chk("rst_dut1", {busy1, done1, fail1, fail_addr1, fail_data1, fail_cnt1}, 32'h0);
        chk("rst_dut3", {busy3, done3, fail3, fail_addr3, fail_data3, fail_cnt3}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        cpu_wr = 1'b1;
        cpu_addr = 4'h3;
        cpu_din = 8'h5C;
        #1;
        chk("mux_wr", {mem_wr1, mem_rd1, mem_addr1, mem_din1}, {1'b1, 1'b0, 4'h3, 8'h5C});
        @(negedge clk);
        cpu_wr = 1'b0;
        cpu_rd = 1'b1;
        #1;
        chk("mux_rd", {mem_wr1, mem_rd1, mem_addr1}, {1'b0, 1'b1, 4'h3});
        @(negedge clk);
        cpu_rd = 1'b0;
        chk("cpu_dout", cpu_dout1, 8'h5C);
        test_mode = 1'b1;
        cpu_wr = 1'b1;
        #1;
        chk("mux_block", {mem_wr1, mem_wr3}, 2'b00);
        cpu_wr = 1'b0;

        run_march(1'b0, 8'h00, 0);
        chk("mats_ops", ops1, 80);
        chk("mats_done1", d1_c, 82);
        chk("mats_done3", d3_c, 84);
        chk("mats_clean", {fail1, fail_cnt1, fail3, fail_cnt3}, 18'h0);
        chk("mats_busy", {busy1, busy3}, 2'b00);

        run_march(1'b1, 8'hA5, 0);
        chk("mc_first_op", {first_wr, first_din}, {1'b1, 8'hA5});
        chk("mc_ops", ops1, 160);
        chk("mc_done1", d1_c, 162);
        chk("mc_done3", d3_c, 164);
        chk("mc_clean", {fail1, fail_cnt1, fail3, fail_cnt3}, 18'h0);

        f1_en = 1'b1;
        f1_a = 4'h9;
        f3_en = 1'b1;
        f3_a = 4'hF;
        run_march(1'b1, 8'h00, 0);
        chk("sa_fail1", {fail1, fail_addr1, fail_data1}, {1'b1, 4'h9, 8'h08});
        chk("sa_fail3", {fail3, fail_addr3, fail_data3}, {1'b1, 4'hF, 8'h08});
`ifdef MBIST_STOP_ON_FAIL_EN
        chk("sa_cnt1", fail_cnt1, 1);
        chk("sa_cnt3", fail_cnt3, 1);
        chk("sa_done1", d1_c, 37);
        chk("sa_done3", d3_c, 51);
`else
        chk("sa_cnt1", fail_cnt1, 3);
        chk("sa_cnt3", fail_cnt3, 3);
        chk("sa_done1", d1_c, 162);
        chk("sa_done3", d3_c, 164);
`endif

        f3_en = 1'b0;
        run_march(1'b1, 8'h00, 40);
        test_mode = 1'b0;
        @(negedge clk);
        chk("abort_state", {busy1, done1, busy3, done3}, 4'b0000);
        chk("abort_keep1", {fail1, fail_addr1, fail_data1, fail_cnt1},
            {1'b1, 4'h9, 8'h08, 8'd1});
        chk("abort_keep3", {fail3, fail_cnt3}, 9'h0);

        run_march(1'b1, 8'h00, 50);
        chk("pre_rst_fail", fail1, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_mid1", {busy1, done1, fail1, fail_cnt1, fail_addr1, fail_data1, mem_rd1, mem_wr1},
            32'h0);
        chk("rst_mid3", {busy3, done3, mem_rd3, mem_wr3}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        run_march(1'b0, 8'hFF, 0);
        chk("bgff_fail1", {fail1, fail_addr1, fail_data1, fail_cnt1},
            {1'b1, 4'h9, 8'h08, 8'd1});
        chk("bgff_clean3", {fail3, fail_cnt3}, 9'h0);
`ifdef MBIST_STOP_ON_FAIL_EN
        chk("bgff_done1", d1_c, 63);
`else
        chk("bgff_done1", d1_c, 82);
`endif
        chk("bgff_done3", d3_c, 84);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mbist_march_subsystem.md
Name: mbist_march_subsystem

Overview:
Next-generation MBIST subsystem for single-port synchronous SRAMs.
- Combines the functional/test memory mux and a March engine.
- Runtime-selectable algorithm (MATS+ or March C-) and programmable data background.
- Pipelined read compare with parametrised read latency.
- First-fail capture (address and syndrome) and a saturating fail counter.
- Sits between CPU-side memory port and the SRAM macro.

Parameters:
ADDR, 4, address width; memory depth N = 2**ADDR
DATA, 8, data width
RD_LAT, 1, cycles from mem_rd strobe to valid mem_dout (1..4)
FCNT_W, 8, fail counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
test_mode  in  1  1 = engine owns memory, 0 = CPU owns memory
start  in  1  run request, sampled when test_mode=1
alg_sel  in  1  0 = MATS+, 1 = March C-; latched at run start
bg_pattern  in  DATA  data background "0"; "1" = ~bg_pattern; latched at run start
cpu_rd  in  1  CPU read strobe
cpu_wr  in  1  CPU write strobe
cpu_addr  in  ADDR  CPU address
cpu_din  in  DATA  CPU write data
cpu_dout  out  DATA  read data to CPU (= mem_dout)
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_addr  out  ADDR  memory address
mem_din  out  DATA  memory write data
mem_dout  in  DATA  memory read data
busy  out  1  run in progress (RUN or DRAIN)
done  out  1  run complete, level
fail  out  1  sticky mismatch flag
fail_addr  out  ADDR  address of first mismatch
fail_data  out  DATA  first-mismatch syndrome: read XOR expected
fail_cnt  out  FCNT_W  mismatch count, saturates at all-ones

Behaviour:
- Reset: FSM=IDLE; busy, done, fail = 0; fail_addr, fail_data, fail_cnt = 0; engine strobes = 0.
- Mux (combinational):
  - test_mode=0: mem_* = cpu_*.
  - test_mode=1: mem_* = engine outputs; cpu_rd and cpu_wr are ignored.
  - cpu_dout = mem_dout always.
- Engine strobes are registered and 0 outside RUN.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE -> RUN when start=1 and test_mode=1.
    - Latch alg_sel and bg_pattern.
    - Clear done, fail, fail_addr, fail_data, fail_cnt.
    - Element index = 0, op index = 0.
  - RUN:
    - Exactly one memory op per cycle, no bubbles, including across element boundaries.
    - Up elements run address 0..N-1; down elements run N-1..0; either-direction elements run up.
    - After the last op of the last element -> DRAIN.
  - DRAIN: RD_LAT cycles with no ops, to retire outstanding compares; then -> DONE.
  - DONE: done=1 and busy=0; held until the next start or until test_mode=0.
- Algorithms (0 = bg, 1 = ~bg):
  - MATS+: (w0); up(r0,w1); down(r1,w0). Total 5N ops.
  - March C-: (w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); (r0). Total 10N ops.
- Compare pipeline:
  - Each read pushes {addr, expected} into an RD_LAT-deep shift register.
  - mem_dout is compared when that entry emerges.
  - On mismatch: fail_cnt += 1 (saturating).
  - On the first mismatch of a run only: fail <= 1, and fail_addr and fail_data are captured.
- Timing: with the start-sampling edge as cycle 0, ops occupy cycles 1..OPS. done rises at cycle OPS + RD_LAT + 1.
- start held high in RUN/DRAIN is ignored. start held high in DONE restarts the run.
- test_mode falling during RUN/DRAIN:
  - Abort to IDLE on the next edge; busy=0, done=0.
  - Pending compares are discarded.
  - fail, fail_addr, fail_data and fail_cnt are retained.
- rst mid-run: immediate return to reset values.

Optional Feature:
MBIST_STOP_ON_FAIL_EN
- Defined: on the first retired mismatch, the engine stops issuing ops and goes directly to DONE on the next edge. Outstanding compares are discarded, so fail_cnt = 1.
- Undefined: the run always completes all elements, and fail_cnt counts every mismatch.

Test Plan:
- ADDR=4, RD_LAT=1, fault-free model, alg_sel=0, bg_pattern=8'h00, start pulse -> exactly 80 ops; done rises at cycle 82; fail=0, fail_cnt=0.
- Same setup with alg_sel=1, bg_pattern=8'hA5 -> 160 ops; first write data 8'hA5; done at cycle 162; fail=0.
- Bit 3 of address 4'h9 stuck-at-1, alg_sel=1, bg_pattern=8'h00 -> fail=1, fail_addr=4'h9, fail_data=8'h08, fail_cnt=3 (the three r0 reads). With MBIST_STOP_ON_FAIL_EN: done on the cycle after the first mismatch, fail_cnt=1.
- test_mode=0, cpu_wr to 4'h3 with 8'h5C, then cpu_rd -> mem_* track cpu_* combinationally and cpu_dout=8'h5C. With test_mode=1, cpu_wr is blocked (mem_wr=0 in IDLE).
- Drop test_mode at op 40 -> busy=0 and done=0 next cycle, fail flags retained. rst asserted mid-run -> all outputs 0 asynchronously.
- RD_LAT=3 with the stuck-at fault at address 4'hF -> fail_addr=4'hF; done at cycle OPS+4; no compare is lost at element boundaries.
